uart_tx: RTL and testbench

//  8N1 UART transmitter; transmit-side companion of uart_rx on the icesugar-nano link.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_if.sv | 9 +
 rtl/uart_baud_gen.sv | 39 +++
 rtl/uart_tx.sv | 155 +++++++++++++++
 tb/tb_uart_tx.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, FSM state encoding and bit-period derivation.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter holding register.
interface uart_tx_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       ready;

  modport master (output data_in, output data_valid, input ready);
  modport slave  (input data_in, input data_valid, output ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and raises tick during the terminal count.
// A start strobe restarts the period so a new frame gets full-length bits.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == TERM);

  // Next count: restart on strobe, wrap at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (start || tick) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a 1-deep holding register, cts gating and back-to-back frames.
// All outputs are registered; tx idles high.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE    = 115200,
  parameter int CLK_FREQ     = 12000000,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE)
) (
  input  logic      clk,
  input  logic      reset,
  uart_tx_if.slave  bus,
  input  logic      cts,
  output logic      tx,
  output logic      busy,
  output logic      tx_done
);

  localparam int IDX_W = $clog2(DATA_BITS);

  uart_state_e          state_q, state_d;
  logic [7:0]           hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [7:0]           shift_q, shift_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ready_q;
  logic                 accept_s;
  logic                 launch_s;
  logic                 tick_s;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .reset (reset),
    .start (launch_s),
    .tick  (tick_s)
  );

  assign accept_s = bus.data_valid && ready_q;
  assign bus.ready = ready_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign tx_done   = done_q;

  // Next-state logic for the holding register and the frame FSM.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    launch_s    = 1'b0;

    if (accept_s) begin
      hold_d      = bus.data_in;
      hold_full_d = 1'b1;
    end else begin
      hold_full_d = hold_full_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q && cts) begin
          launch_s = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_START: begin
        if (tick_s) begin
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
          bit_idx_d = {IDX_W{1'b0}};
        end else begin
          tx_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          tx_d = tx_q;
        end
      end
      ST_STOP: begin
        if (tick_s) begin
          done_d = 1'b1;
          if (hold_full_q && cts) begin
            launch_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          tx_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Launch never coincides with an accept: ready is low whenever a byte is held.
    if (launch_s) begin
      state_d     = ST_START;
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      tx_d        = 1'b0;
      busy_d      = 1'b1;
      bit_idx_d   = {IDX_W{1'b0}};
    end else begin
      shift_d = shift_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      shift_q     <= 8'h00;
      bit_idx_q   <= {IDX_W{1'b0}};
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ready_q     <= !hold_full_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed scenarios plus randomized traffic, compared every
// cycle against a frame-timeline model of the 8N1 line.
module tb_uart_tx;

  localparam int CLK_FREQ  = 1000000;
  localparam int BAUD_RATE = 100000;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
  localparam int FRAME_CYC = 10 * CPB;

  logic clk = 1'b0;
  logic reset;
  logic cts;
  logic tx, busy, tx_done;

  uart_tx_if bus_if ();

  uart_tx #(.BAUD_RATE(BAUD_RATE), .CLK_FREQ(CLK_FREQ)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .cts     (cts),
    .tx      (tx),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: pending byte, and the frame currently on the line with its elapsed cycle count.
  bit       m_hold_full;
  bit [7:0] m_hold;
  bit       m_active;
  int       m_t;
  bit [7:0] m_byte;
  bit       m_done;
  bit       m_accepted;
  int       m_frames;
  int       obs_frames;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit line_level(input bit [7:0] b, input int t);
    int k;
    k = t / CPB;
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[k-1];
    else return 1'b1;
  endfunction

  task automatic model_edge();
    bit start_ok;
    m_done = 1'b0;
    m_accepted = 1'b0;
    if (reset) begin
      m_hold_full = 1'b0;
      m_active = 1'b0;
      m_t = 0;
    end else begin
      start_ok = m_hold_full && cts;
      if (m_active && m_t == FRAME_CYC - 1) begin
        m_done = 1'b1;
        m_frames++;
        m_active = 1'b0;
      end else if (m_active) begin
        m_t++;
      end
      if (!m_active && start_ok && (m_done || m_t != FRAME_CYC - 1 || 1'b1)) begin
        m_active = 1'b1;
        m_t = 0;
        m_byte = m_hold;
        m_hold_full = 1'b0;
      end
      if (bus_if.data_valid && !m_hold_full && !start_ok) begin
        m_hold_full = 1'b1;
        m_hold = bus_if.data_in;
        m_accepted = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("tx", tx, m_active ? line_level(m_byte, m_t) : 1'b1);
    check_eq("busy", busy, m_active);
    check_eq("tx_done", tx_done, m_done);
    check_eq("ready", bus_if.ready, !m_hold_full);
    if (tx_done === 1'b1) obs_frames++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [7:0] b);
    int waited;
    bus_if.data_in = b;
    bus_if.data_valid = 1'b1;
    waited = 0;
    do begin
      step();
      waited++;
      if (waited > 40) cts = 1'b1;
    end while (!m_accepted && waited < 2000);
    if (!m_accepted) check_eq("accept_timeout", 32'd0, 32'd1);
    bus_if.data_valid = 1'b0;
    bus_if.data_in = $urandom_range(0, 255);
  endtask

  initial begin
    m_hold_full = 1'b0;
    m_hold = 8'h00;
    m_active = 1'b0;
    m_t = 0;
    m_byte = 8'h00;
    m_frames = 0;
    obs_frames = 0;
    cts = 1'b1;
    bus_if.data_in = 8'h11;
    bus_if.data_valid = 1'b1;
    reset = 1'b1;
    #1;

    // 1: reset with data_valid high, nothing accepted
    run(3);
    bus_if.data_valid = 1'b0;
    reset = 1'b0;
    run(5);

    // 2: single 0x55 frame
    send(8'h55);
    run(FRAME_CYC + 10);

    // 3: back-to-back frames
    send(8'hA5);
    run(30);
    send(8'h3C);
    run(2 * FRAME_CYC + 10);

    // 4: cts gating and mid-frame cts drop
    cts = 1'b0;
    send(8'h81);
    run(20);
    cts = 1'b1;
    run(45);
    cts = 1'b0;
    run(FRAME_CYC);
    cts = 1'b1;
    run(5);

    // 5: reset during data bit 3, then clean frame
    send(8'hF0);
    run(1 + 3 * CPB + 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    run(5);
    send(8'h0F);
    run(FRAME_CYC + 10);

    // 6: data_in churn while the holding register is full
    cts = 1'b0;
    send(8'h96);
    bus_if.data_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus_if.data_in = $urandom_range(0, 255);
      step();
    end
    bus_if.data_valid = 1'b0;
    cts = 1'b1;
    run(FRAME_CYC + 10);

    // Randomized traffic with random gaps and cts
    for (int i = 0; i < 60; i++) begin
      cts = ($urandom_range(0, 3) != 0);
      run($urandom_range(0, 3) * $urandom_range(0, 40));
      send($urandom_range(0, 255));
    end
    cts = 1'b1;
    run(3 * FRAME_CYC);

    check_eq("frame_count", obs_frames, m_frames);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
